key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_if.sv | 12 +
 rtl/key_debounce_ch.sv | 131 +++++++++++++
 rtl/key_debounce.sv | 41 ++++
 tb/tb_key_debounce.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key_debounce slice.
// Timing defaults assume a 50 MHz fabric clock.
package key_debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } db_state_e;

    localparam int unsigned DEB_20MS        = 1000000;
    localparam int unsigned REP_DELAY_500MS = 25000000;
    localparam int unsigned REP_RATE_100MS  = 5000000;

    // Bits needed to hold 0..n-1
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Pin-side bundle of the debouncer: raw pins in, debounced levels and strobes out.
interface key_debounce_if #(
    parameter int unsigned NUM_CH = 4
) ();
    logic [NUM_CH-1:0] raw_in;
    logic [NUM_CH-1:0] db_out;
    logic [NUM_CH-1:0] press_pulse;
    logic [NUM_CH-1:0] release_pulse;

    modport master (output raw_in, input db_out, press_pulse, release_pulse);
    modport slave  (input raw_in, output db_out, press_pulse, release_pulse);
endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, STABLE/COUNT FSM and stability counter.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add press_pulse auto-repeat while held.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS,
    parameter bit          RESET_LEVEL     = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b1
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = REP_DELAY_500MS,
    parameter int unsigned REPEAT_RATE     = REP_RATE_100MS
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned      CNT_W       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic             PRESS_LEVEL = ACTIVE_LOW ? 1'b0 : 1'b1;

    logic             sync1, sync2;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned      REP_W     = cnt_width(max_u(REPEAT_DELAY, REPEAT_RATE));
    localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_q, rep_d;
    logic             rep_first_q, rep_first_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= RESET_LEVEL;
            sync2       <= RESET_LEVEL;
            state_q     <= STABLE;
            cnt_q       <= '0;
            db_q        <= RESET_LEVEL;
            press_q     <= 1'b0;
            rel_q       <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rep_q       <= '0;
            rep_first_q <= 1'b0;
`endif
        end else begin
            sync1       <= raw;
            sync2       <= sync1;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            db_q        <= db_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rep_q       <= rep_d;
            rep_first_q <= rep_first_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2 != db_q) begin
                    state_d = COUNT;
                    cnt_d   = CNT_W'(1);
                end
            end
            COUNT: begin
                if (sync2 == db_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    db_d    = sync2;
                    press_d = (sync2 == PRESS_LEVEL);
                    rel_d   = (sync2 != PRESS_LEVEL);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        // An accepted release wins over a repeat due in the same cycle
        rep_d       = rep_q;
        rep_first_d = rep_first_q;
        if (press_d) begin
            rep_d       = '0;
            rep_first_d = 1'b0;
        end else if (db_q == PRESS_LEVEL && !rel_d) begin
            if (rep_q == (rep_first_q ? RATE_LAST : DLY_LAST)) begin
                press_d     = 1'b1;
                rep_d       = '0;
                rep_first_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end else begin
            rep_d       = '0;
            rep_first_d = 1'b0;
        end
`endif
    end

    assign db            = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;

endmodule

// File: rtl/key_debounce.sv
// Multi-channel key/DIP-switch debouncer feeding the button/dipsw PIO exports.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to enable press auto-repeat (REPEAT_DELAY/REPEAT_RATE).
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS,
    parameter bit          RESET_LEVEL     = 1'b1,
    parameter bit          ACTIVE_LOW      = 1'b1
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = REP_DELAY_500MS,
    parameter int unsigned REPEAT_RATE     = REP_RATE_100MS
`endif
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    key_debounce_if.slave  keys
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL),
            .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
`endif
        ) u_ch (
            .clk           (clk_clk),
            .rst_n         (reset_reset_n),
            .raw           (keys.raw_in[i]),
            .db            (keys.db_out[i]),
            .press_pulse   (keys.press_pulse[i]),
            .release_pulse (keys.release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key activity
// compared against a run-length reference model of the debounce rules.
module tb_key_debounce;

    localparam int unsigned DEB = 8;
    localparam int unsigned RD  = 20;
    localparam int unsigned RR  = 5;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad = 0;

    key_debounce_if #(.NUM_CH(4)) keys ();

    key_debounce #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (DEB),
        .RESET_LEVEL     (1'b1),
        .ACTIVE_LOW      (1'b1)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        ,
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
`endif
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .keys          (keys)
    );

    always #10 clk_clk = ~clk_clk;

    // Reference model: pins reach the decision logic two edges late; a level is
    // accepted once DEB consecutive observations disagree with the current level.
    logic [3:0]  m_q[$];
    logic [3:0]  m_db, m_press, m_rel;
    int unsigned m_run[4];
    int unsigned m_since[4];
    int unsigned m_target[4];

    task automatic model_reset();
        m_q.delete();
        m_q.push_back(4'hF);
        m_q.push_back(4'hF);
        m_db    = 4'hF;
        m_press = 4'h0;
        m_rel   = 4'h0;
        for (int c = 0; c < 4; c++) begin
            m_run[c]    = 0;
            m_since[c]  = 0;
            m_target[c] = RD;
        end
    endtask

    task automatic model_edge(input logic [3:0] raw);
        logic [3:0] obs;
        logic       acc;
        obs = m_q.pop_front();
        m_q.push_back(raw);
        m_press = 4'h0;
        m_rel   = 4'h0;
        for (int c = 0; c < 4; c++) begin
            acc = 1'b0;
            if (obs[c] != m_db[c]) begin
                m_run[c]++;
                if (m_run[c] == DEB) begin
                    acc        = 1'b1;
                    m_db[c]    = obs[c];
                    m_press[c] = ~obs[c];
                    m_rel[c]   = obs[c];
                    m_run[c]   = 0;
                    m_since[c] = 0;
                    m_target[c] = RD;
                end
            end else begin
                m_run[c] = 0;
            end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            if (!acc && m_db[c] == 1'b0) begin
                m_since[c]++;
                if (m_since[c] == m_target[c]) begin
                    m_press[c]  = 1'b1;
                    m_since[c]  = 0;
                    m_target[c] = RR;
                end
            end
`endif
        end
    endtask

    // Called at a falling edge; drives raw, advances one clock, returns at the next falling edge
    task automatic cycle(input logic [3:0] raw);
        keys.raw_in = raw;
        @(posedge clk_clk);
        if (reset_reset_n) model_edge(raw);
        @(negedge clk_clk);
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        keys.raw_in = 4'b0000;
        model_reset();
        repeat (3) @(negedge clk_clk);
        total++;
        if (keys.db_out !== 4'hF) begin
            bad++;
            $display("FAIL reset_db: got %b want 1111", keys.db_out);
        end
        total++;
        if ({keys.press_pulse, keys.release_pulse} !== 8'h00) begin
            bad++;
            $display("FAIL reset_pulse: got p=%b r=%b want 0", keys.press_pulse, keys.release_pulse);
        end
        keys.raw_in = 4'hF;
        reset_reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle(4'hF);
            total++;
            if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {4'hF, 8'h00}) begin
                bad++;
                $display("FAIL reset_release cyc=%0d: got db=%b p=%b r=%b want db=1111 p=0 r=0",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int i = 0; i < 12; i++) begin
            cycle(4'b1110);
            total++;
            if (keys.db_out !== ((i >= 9) ? 4'b1110 : 4'b1111) ||
                keys.press_pulse !== ((i == 9) ? 4'b0001 : 4'b0000) || keys.release_pulse !== 4'h0) begin
                bad++;
                $display("FAIL clean_press cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=0000",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse,
                         (i >= 9) ? 4'b1110 : 4'b1111, (i == 9) ? 4'b0001 : 4'b0000);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(4'hF);
            total++;
            if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {m_db, m_press, m_rel} ||
                keys.release_pulse !== ((i == 9) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL clean_release cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=%b",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse, m_db, m_press, m_rel);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] r;
        for (int i = 0; i < 72; i++) begin
            r = 4'hF;
            if (i < 60) r[1] = ((i / 3) % 2 == 1);
            cycle(r);
            total++;
            if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {4'hF, 8'h00}) begin
                bad++;
                $display("FAIL bounce cyc=%0d: got db=%b p=%b r=%b want db=1111 p=0 r=0",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse);
            end
        end
    endtask

    task automatic test_near_miss();
        int unsigned presses;
        for (int i = 0; i < 20; i++) begin
            cycle((i < 7) ? 4'b1011 : 4'hF);
            total++;
            if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {4'hF, 8'h00}) begin
                bad++;
                $display("FAIL near_miss7 cyc=%0d: got db=%b p=%b r=%b want db=1111 p=0 r=0",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse);
            end
        end
        presses = 0;
        for (int i = 0; i < 30; i++) begin
            cycle((i < 8) ? 4'b1011 : 4'hF);
            if (keys.press_pulse[2]) presses++;
            total++;
            if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {m_db, m_press, m_rel} ||
                (i == 9 && keys.press_pulse !== 4'b0100)) begin
                bad++;
                $display("FAIL near_miss8 cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=%b",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse, m_db, m_press, m_rel);
            end
        end
        total++;
        if (presses != 1) begin
            bad++;
            $display("FAIL near_miss8_count: got %0d presses want 1", presses);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 12; i++) begin
            cycle(4'h0);
            total++;
            if (keys.press_pulse !== ((i == 9) ? 4'hF : 4'h0) ||
                {keys.db_out, keys.release_pulse} !== {m_db, m_rel}) begin
                bad++;
                $display("FAIL simul_press cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=%b",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse,
                         m_db, (i == 9) ? 4'hF : 4'h0, m_rel);
            end
        end
        for (int i = 0; i < 12; i++) begin
            cycle(4'hF);
            total++;
            if (keys.release_pulse !== ((i == 9) ? 4'hF : 4'h0) ||
                {keys.db_out, keys.press_pulse} !== {m_db, m_press}) begin
                bad++;
                $display("FAIL simul_release cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=%b",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse,
                         m_db, m_press, (i == 9) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cycle(4'b0111);
        reset_reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {4'hF, 8'h00}) begin
            bad++;
            $display("FAIL reset_mid_assert: got db=%b p=%b r=%b want db=1111 p=0 r=0",
                     keys.db_out, keys.press_pulse, keys.release_pulse);
        end
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(4'b0111);
            total++;
            if (keys.db_out !== ((i >= 9) ? 4'b0111 : 4'b1111) ||
                keys.press_pulse !== ((i == 9) ? 4'b1000 : 4'b0000) || keys.release_pulse !== 4'h0) begin
                bad++;
                $display("FAIL reset_mid_full cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=0000",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse,
                         (i >= 9) ? 4'b0111 : 4'b1111, (i == 9) ? 4'b1000 : 4'b0000);
            end
        end
        for (int i = 0; i < 12; i++) cycle(4'hF);
        total++;
        if (keys.db_out !== 4'hF) begin
            bad++;
            $display("FAIL reset_mid_settle: got db=%b want 1111", keys.db_out);
        end
    endtask

    task automatic test_random();
        logic [3:0]  r;
        int unsigned hold[4];
        r = 4'hF;
        for (int c = 0; c < 4; c++) hold[c] = 0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    r[c] = ~r[c];
                    hold[c] = $urandom_range(1, 12);
                end
                hold[c]--;
            end
            cycle((n < 385) ? r : 4'hF);
            total++;
            if ({keys.db_out, keys.press_pulse, keys.release_pulse} !== {m_db, m_press, m_rel} ||
                (keys.press_pulse & keys.release_pulse) !== 4'h0) begin
                bad++;
                $display("FAIL random cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=%b",
                         n, keys.db_out, keys.press_pulse, keys.release_pulse, m_db, m_press, m_rel);
            end
        end
    endtask

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    task automatic test_autorepeat();
        logic exp_p;
        for (int i = 0; i < 70; i++) begin
            cycle((i < 40) ? 4'b1110 : 4'hF);
            exp_p = (i == 9 || i == 29 || i == 34 || i == 39 || i == 44);
            total++;
            if (keys.press_pulse !== {3'b000, exp_p} ||
                keys.release_pulse !== ((i == 49) ? 4'b0001 : 4'b0000) ||
                {keys.db_out, keys.press_pulse, keys.release_pulse} !== {m_db, m_press, m_rel}) begin
                bad++;
                $display("FAIL autorepeat cyc=%0d: got db=%b p=%b r=%b want db=%b p=%b r=%b",
                         i, keys.db_out, keys.press_pulse, keys.release_pulse, m_db, m_press, m_rel);
            end
        end
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_near_miss();
        test_simultaneous();
        test_reset_mid();
        test_random();
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
